// File: rtl/bus_pkg.sv
// Shared types and widths for the memory-side bus responder.
package bus_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } bus_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } bus_op_t;

endpackage

// File: rtl/word_memory.sv
// Word array with a reset-time clear, a synchronous write port and a
// combinational read port that share one index.
module word_memory #(
  parameter int DEPTH  = 64,
  parameter int WORD_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory end of the CPU bus: latches a read/write request, waits a fixed
// number of cycles, then answers with data and a one-cycle bus_full strobe.
module mem_bus_responder
  import bus_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_req,
  input  logic              write_req,
  input  logic [WORD_W-1:0] address_in,
  input  logic [WORD_W-1:0] data_in,
  output logic [WORD_W-1:0] data_out,
  output logic              bus_full,
  output logic              busy,
  output logic              addr_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;

  bus_state_t        state_q, state_d;
  bus_op_t           op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] data_out_q, data_out_d;
  logic              err_q, err_d;
  logic              bus_full_q, bus_full_d;
  logic              busy_q, busy_d;
  logic              addr_err_q, addr_err_d;

  logic              enter_respond;
  logic              bad_addr;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  word_memory #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .idx   (addr_d[IDX_W+1:2]),
    .wdata (wdata_d),
    .rdata (mem_rdata)
  );

  // Decode and memory access use the _d view of the latched request so that
  // a LATENCY=1 request, which enters RESPOND on its accept edge, works too.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    err_d      = err_q;

    unique case (state_q)
      IDLE: begin
        if (read_req || write_req) begin
          addr_d  = address_in;
          wdata_d = data_in;
          op_d    = write_req ? OP_WRITE : OP_READ;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY > 1) ? WAIT : RESPOND;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    bad_addr      = (addr_d[1:0] != 2'b00) || (addr_d[WORD_W-1:IDX_W+2] != '0);
    enter_respond = (state_d == RESPOND) && (state_q != RESPOND);
    mem_we        = enter_respond && (op_d == OP_WRITE) && !bad_addr;

    if (enter_respond) begin
      err_d = bad_addr;
      if (bad_addr) begin
        data_out_d = '0;
      end else if (op_d == OP_WRITE) begin
        data_out_d = wdata_d;
      end else begin
        data_out_d = mem_rdata;
      end
    end

    // Strobes trail the RESPOND state by one edge; busy spans the strobe cycle.
    bus_full_d = (state_q == RESPOND);
    addr_err_d = (state_q == RESPOND) && err_q;
    busy_d     = (state_d != IDLE) || (state_q == RESPOND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_READ;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
      err_q      <= 1'b0;
      bus_full_q <= 1'b0;
      busy_q     <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
      bus_full_q <= bus_full_d;
      busy_q     <= busy_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign data_out = data_out_q;
  assign bus_full = bus_full_q;
  assign busy     = busy_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: four instances with different
// latencies, each request pushes its expected response, a monitor pops it.
module tb_mem_bus_responder;

   localparam int NINST = 4;
   localparam int LATS [NINST] = '{2, 4, 1, 15};

   typedef struct {
      int          idx;
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        rd   [NINST];
   logic        wr   [NINST];
   logic [31:0] addr [NINST];
   logic [31:0] wdat [NINST];
   logic [31:0] dout [NINST];
   logic        bf   [NINST];
   logic        busy [NINST];
   logic        aerr [NINST];

   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sbq [$];
   logic bfPrev [NINST] = '{default: 1'b0};

   for (genvar g = 0; g < NINST; g++) begin : gInst
      mem_bus_responder #(
         .DEPTH   (64),
         .LATENCY (LATS[g])
      ) dut (
         .clk        (clk),
         .rst        (rst),
         .read_req   (rd[g]),
         .write_req  (wr[g]),
         .address_in (addr[g]),
         .data_in    (wdat[g]),
         .data_out   (dout[g]),
         .bus_full   (bf[g]),
         .busy       (busy[g]),
         .addr_err   (aerr[g])
      );
   end

   // Free-running clock and a cycle count that advances on each rising edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point: counts every vector and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %h, expected %h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Drive one request on instance i, record what it should answer and when,
   // then follow busy until the transaction is over.
   task automatic applyStimulus(input int i, input logic r, input logic w,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] expData, input logic expErr);
      exp_t e;
      int   k;
      int   cnt;
      rd[i]   = r;
      wr[i]   = w;
      addr[i] = a;
      wdat[i] = d;
      k       = cyc + 1;
      e.idx   = i;
      e.data  = expData;
      e.err   = expErr;
      e.cyc   = k + LATS[i];
      sbq.push_back(e);
      @(negedge clk);
      rd[i] = 1'b0;
      wr[i] = 1'b0;
      checkOutput("busy_rise", 32'(busy[i]), 32'd1);
      cnt = 1;
      while (busy[i] === 1'b1 && cnt < 40) begin
         @(negedge clk);
         if (busy[i] === 1'b1) cnt++;
      end
      checkOutput("busy_len", cnt, LATS[i] + 1);
   endtask

   // Response monitor: every bus_full pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < NINST; i++) begin
         if (bf[i] === 1'b1) begin
            checkOutput("bf_consecutive", 32'(bfPrev[i]), 32'd0);
            if (sbq.size() == 0) begin
               checkOutput("bf_spurious", 32'd1, 32'd0);
            end else begin
               e = sbq.pop_front();
               checkOutput("resp_inst", i, e.idx);
               checkOutput("resp_cycle", cyc, e.cyc);
               checkOutput("data_out", dout[i], e.data);
               checkOutput("addr_err", 32'(aerr[i]), 32'(e.err));
            end
         end else if (aerr[i] === 1'b1) begin
            checkOutput("aerr_without_bf", 32'd1, 32'd0);
         end
         bfPrev[i] = bf[i];
      end
   end

   // Hard stop in case anything wedges the main sequence.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence of directed scenarios.
   initial begin
      exp_t e;
      int   k;
      int   cnt;
      for (int i = 0; i < NINST; i++) begin
         rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdat[i] = '0;
      end
      rst = 1'b0;
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_data_out", dout[0], 32'd0);
      checkOutput("rst_bus_full", 32'(bf[0]), 32'd0);
      checkOutput("rst_busy", 32'(busy[0]), 32'd0);
      checkOutput("rst_addr_err", 32'(aerr[0]), 32'd0);

      // Reset in the middle of a LATENCY=4 write drops it entirely.
      wr[1] = 1'b1; addr[1] = 32'h8; wdat[1] = 32'hDEADBEEF;
      @(negedge clk);
      wr[1] = 1'b0;
      checkOutput("midrst_busy_pre", 32'(busy[1]), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midrst_busy", 32'(busy[1]), 32'd0);
      checkOutput("midrst_bus_full", 32'(bf[1]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      applyStimulus(1, 1'b1, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);

      // Write then read back at LATENCY=2, then data_out must hold.
      applyStimulus(0, 1'b0, 1'b1, 32'h4, 32'h1, 32'h1, 1'b0);
      applyStimulus(0, 1'b1, 1'b0, 32'h4, 32'h0, 32'h1, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("dout_hold", dout[0], 32'h1);

      // Latency extremes.
      applyStimulus(2, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      applyStimulus(3, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

      // Simultaneous read and write is a write.
      applyStimulus(0, 1'b1, 1'b1, 32'hC, 32'd32, 32'd32, 1'b0);
      applyStimulus(0, 1'b1, 1'b0, 32'hC, 32'h0, 32'd32, 1'b0);

      // Bad addresses: misaligned and out of range, write must not land.
      applyStimulus(0, 1'b1, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1);
      applyStimulus(0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
      applyStimulus(0, 1'b0, 1'b1, 32'h0, 32'h11111111, 32'h11111111, 1'b0);
      applyStimulus(0, 1'b0, 1'b1, 32'h100, 32'h00BADBAD, 32'h0, 1'b1);
      applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h11111111, 1'b0);
      applyStimulus(0, 1'b1, 1'b0, 32'h4, 32'h0, 32'h1, 1'b0);

      // read_req held high: a new accept every LATENCY+1 cycles.
      rd[0] = 1'b1; addr[0] = 32'hC;
      k = cyc + 1;
      for (int n = 0; n < 3; n++) begin
         e.idx  = 0;
         e.data = 32'd32;
         e.err  = 1'b0;
         e.cyc  = k + n * (LATS[0] + 1) + LATS[0];
         sbq.push_back(e);
      end
      while (cyc < k + 2 * (LATS[0] + 1)) @(negedge clk);
      rd[0] = 1'b0;
      cnt = 0;
      while (busy[0] === 1'b1 && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      repeat (2) @(negedge clk);
      checkOutput("b2b_idle", 32'(busy[0]), 32'd0);
      checkOutput("sb_drain", sbq.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
